rr_mux_arb: RTL

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. It supersedes the fixed-width combinational selectors for datapath points where several producers contend for one consumer, such as register-file write-back or memory request merge. It selects one requesting channel per cycle, using either round-robin or fixed-priority arbitration. The winning word is captured into a one-entry output register, which sustains one transfer per clock.

---
 rtl/rr_mux_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel valid/ready multiplexer with a one-entry output register.
// Grants one requester per cycle, round-robin or fixed priority.
module rr_mux_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int RR    = 1,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH-1:0]       IN_VALID,
    input  logic [NCH*WIDTH-1:0] IN_DATA,
    output logic [NCH-1:0]       IN_READY,
    output logic                 OUT_VALID,
    output logic [WIDTH-1:0]     OUT_DATA,
    output logic [SELW-1:0]      OUT_SEL,
    input  logic                 OUT_READY
);

    logic              r_vld;
    logic [WIDTH-1:0]  r_data;
    logic [SELW-1:0]   r_sel;
    logic [SELW-1:0]   r_ptr;

    logic              w_accept;
    logic              w_gnt_vld;
    logic [SELW-1:0]   w_gnt_idx;
    logic [SELW-1:0]   w_idx;
    logic [WIDTH-1:0]  w_gnt_data;
    logic [SELW-1:0]   w_ptr_nxt;
    int                w_j;

    assign w_accept = !r_vld || OUT_READY;

    // Search starts at the pointer and wraps; in fixed mode the pointer stays 0.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_j       = 0;
        for (int k = 0; k < NCH; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NCH) begin
                w_j = w_j - NCH;
            end
            w_idx = SELW'(w_j);
            if (!w_gnt_vld && IN_VALID[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data = IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        IN_READY = '0;
        if (RST && w_accept && w_gnt_vld) begin
            IN_READY[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == SELW'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            if (w_gnt_vld) begin
                r_vld  <= 1'b1;
                r_data <= w_gnt_data;
                r_sel  <= w_gnt_idx;
                if (RR != 0) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

    assign OUT_VALID = r_vld;
    assign OUT_DATA  = r_data;
    assign OUT_SEL   = r_sel;

endmodule
